data_sram_resp: RTL
===================

Name: data_sram_resp

Overview:
- Responder (slave) end of the CPU's data SRAM port. Consumes data_sram_en/we/addr/wdata from the core and returns data_sram_rdata.
- Backed by an on-chip word array, with programmable wait states.
- Raises stallreq_mem to the pipeline controller while an access is in progress, so the pipeline holds, and reports illegal (out-of-window) accesses.
- Serves as the simulation and FPGA memory model behind the core until the AXI bridge exists.

Parameters:
- ADDR_WD, 12, word-index width; the array holds 2^ADDR_WD 32-bit words (default 16 KiB).
- BASE_ADDR, 32'h1c00_0000, byte base of the decoded window; must be aligned to 2^(ADDR_WD+2).
- WAIT_CYCLES, 0, extra stall cycles per access (0..15).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- data_sram_en  input  1  access request
- data_sram_we  input  4  byte write enables; 4'b0000 with en=1 means read
- data_sram_addr  input  32  byte address; bits [1:0] ignored
- data_sram_wdata  input  32  write data; lane i is bits [8i+7:8i]
- data_sram_rdata  output  32  registered read data
- stallreq_mem  output  1  request to hold the pipeline while the access is in flight
- access_err  output  1  sticky flag: an access fell outside the window

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high.
- Reset values:
  - data_sram_rdata = 0, stallreq_mem = 0, access_err = 0.
  - FSM state = IDLE, wait counter = 0.
  - Array contents are not reset.
- In-window test: (addr & ~(2^(ADDR_WD+2)-1)) == BASE_ADDR. Word index = addr[ADDR_WD+1:2].
- FSM states: IDLE, WAIT.
- IDLE, data_sram_en=1 in cycle T (acceptance):
  - WAIT_CYCLES=0:
    - Write: lanes with we[i]=1 are updated at the end of cycle T.
    - Read: rdata loads the array word at the end of cycle T and is valid from cycle T+1.
    - stallreq_mem stays 0.
    - Back-to-back accesses are accepted every cycle.
  - WAIT_CYCLES=N>0:
    - The request is latched: addr, we, wdata and the in-window result.
    - stallreq_mem = 1 combinationally in cycle T and registered-high for cycles T+1..T+N-1.
    - FSM goes to WAIT with the counter set to N-1.
    - The access is performed at the end of cycle T+N-1 using the latched values. Read data is valid from cycle T+N.
    - FSM returns to IDLE in cycle T+N.
- WAIT:
  - The counter decrements each cycle.
  - Core inputs are ignored; the initiator holds them stable because it is stalled.
  - No new request is accepted until IDLE.
- data_sram_rdata holds its last value when no read completes. Writes do not change it.
- Write then read of the same word in the next accepted access returns the new data. There is no read-during-write hazard, because each access is one array operation.
- Out-of-window access:
  - Write is dropped.
  - Read loads 32'h0.
  - access_err is set at the same edge the access completes and stays set until reset.
  - Stall timing is identical to a legal access.
- A write is one with en=1 and any we bit set. A partial write leaves unselected lanes unchanged.
- Reset asserted mid-WAIT: the pending access is discarded (no array write), FSM goes to IDLE, stallreq_mem goes to 0 in the next cycle.
- en=0 in IDLE: no state change.

Optional Feature:
- Macro: DATA_SRAM_RESP_CNT_EN.
- Defined: adds outputs rd_cnt[31:0] and wr_cnt[31:0]. Each increments by 1 at the completion edge of every read or write, in-window or not. Both saturate at 32'hffff_ffff and reset to 0.
- Undefined: the ports and logic are absent. Core behaviour is identical.

Test Plan:
- WAIT_CYCLES=0:
  - Write we=4'hf, addr=0x1c00_0010, wdata=0xdead_beef at cycle T.
  - Read the same address at T+1 -> rdata=0xdead_beef in T+2.
  - stallreq_mem=0 throughout.
- Partial write:
  - Word holds 0x1122_3344; write we=4'b0101, wdata=0xaabb_ccdd.
  - Read back -> 0x11bb_33dd.
- WAIT_CYCLES=3:
  - Read accepted at T -> stallreq_mem=1 in T, T+1, T+2 and 0 in T+3.
  - rdata is the new word from T+3.
  - Toggling addr during T+1..T+2 has no effect.
- Out of window:
  - Read 0x0000_0040 -> rdata=0 and access_err=1 next cycle.
  - A following legal write at 0x1c00_0000 succeeds; access_err stays 1.
- Reset mid-WAIT:
  - WAIT_CYCLES=4; write to 0x1c00_0020 accepted; reset in T+2.
  - stallreq_mem=0 from T+3; later read of 0x1c00_0020 returns its old value.
- With DATA_SRAM_RESP_CNT_EN:
  - 5 reads plus 3 writes -> rd_cnt=5, wr_cnt=3.
  - Forcing rd_cnt to 0xffff_ffff then one more read -> rd_cnt stays 0xffff_ffff.

Source files
------------

// File: rtl/data_sram_resp_if.sv
// Data SRAM port bundle between the core (master) and the memory responder (slave).
// Carries the request (en/we/addr/wdata), the registered read data, the stall request and
// the sticky error flag; rd_cnt/wr_cnt exist only when DATA_SRAM_RESP_CNT_EN is defined.
interface data_sram_resp_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        stallreq_mem;
   logic        access_err;
`ifdef DATA_SRAM_RESP_CNT_EN
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;

   modport master (
      output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
      input  data_sram_rdata, stallreq_mem, access_err, rd_cnt, wr_cnt
   );
   modport slave (
      input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
      output data_sram_rdata, stallreq_mem, access_err, rd_cnt, wr_cnt
   );
`else
   modport master (
      output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
      input  data_sram_rdata, stallreq_mem, access_err
   );
   modport slave (
      input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
      output data_sram_rdata, stallreq_mem, access_err
   );
`endif
endinterface

// File: rtl/data_sram_resp.sv
// Purpose : responder end of the core's data SRAM port, backed by an on-chip word array.
// Latency : access completes at the end of cycle T+max(WAIT_CYCLES,1)-1; read data valid the cycle after.
// Backpres: stallreq_mem holds the pipeline while a wait-stated access is in flight; no queueing.
// Ports   : clk, reset (sync, active-high); sram (slave modport): en/we/addr/wdata in,
//           rdata/stallreq_mem/access_err out (+ rd_cnt/wr_cnt when DATA_SRAM_RESP_CNT_EN is defined).
// Optional: macro DATA_SRAM_RESP_CNT_EN adds saturating read/write completion counters.
module data_sram_resp #(
   parameter int          ADDR_WD     = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h1c00_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic            clk,
   input  logic            reset,
   data_sram_resp_if.slave sram
);
   localparam int          WORDS    = 1 << ADDR_WD;
   localparam logic [31:0] WIN_MASK = ~((32'd1 << (ADDR_WD + 2)) - 32'd1);
   localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);
   // With 0 or 1 wait states the access completes in the accepting cycle, so the
   // live inputs are used directly and the WAIT state is never entered.
   localparam bit          DIRECT   = (WAIT_CYCLES <= 1);
   localparam bit          STALLS   = (WAIT_CYCLES > 0);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              r_state, w_state_nxt;
   logic [3:0]          r_cnt, w_cnt_nxt;
   logic [ADDR_WD-1:0]  r_idx;
   logic [3:0]          r_we;
   logic [31:0]         r_wdata;
   logic                r_win;
   logic [31:0]         r_rdata;
   logic                r_err;
   logic [31:0]         r_mem [WORDS];

   logic                w_in_win;
   logic [ADDR_WD-1:0]  w_in_idx;
   logic                w_accept;
   logic                w_fire;
   logic [ADDR_WD-1:0]  w_acc_idx;
   logic [3:0]          w_acc_we;
   logic [31:0]         w_acc_wdata;
   logic                w_acc_win;
   logic                w_acc_rd;

   assign w_in_win = (sram.data_sram_addr & WIN_MASK) == BASE_ADDR;
   assign w_in_idx = sram.data_sram_addr[ADDR_WD+1:2];
   assign w_accept = (r_state == S_IDLE) && sram.data_sram_en;
   assign w_acc_rd = (w_acc_we == 4'b0000);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fire      = 1'b0;
      w_acc_idx   = w_in_idx;
      w_acc_we    = sram.data_sram_we;
      w_acc_wdata = sram.data_sram_wdata;
      w_acc_win   = w_in_win;
      case (r_state)
         S_IDLE: begin
            if (sram.data_sram_en) begin
               if (DIRECT) begin
                  w_fire = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            // Core inputs are ignored here; only the latched request matters.
            w_acc_idx   = r_idx;
            w_acc_we    = r_we;
            w_acc_wdata = r_wdata;
            w_acc_win   = r_win;
            if (r_cnt == 4'd1) begin
               w_fire      = 1'b1;
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept && !DIRECT) begin
            r_idx   <= w_in_idx;
            r_we    <= sram.data_sram_we;
            r_wdata <= sram.data_sram_wdata;
            r_win   <= w_in_win;
         end
         if (w_fire) begin
            if (w_acc_rd) begin
               r_rdata <= w_acc_win ? r_mem[w_acc_idx] : 32'h0;
            end
            if (!w_acc_win) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   // Array is not reset; reset only suppresses a completing write.
   always_ff @(posedge clk) begin
      if (!reset && w_fire && w_acc_win) begin
         for (int i = 0; i < 4; i++) begin
            if (w_acc_we[i]) begin
               r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
         end
      end
   end

   // Combinational in the accepting cycle, then held by the WAIT state.
   assign sram.stallreq_mem    = (r_state == S_WAIT) || (w_accept && STALLS);
   assign sram.data_sram_rdata = r_rdata;
   assign sram.access_err      = r_err;

`ifdef DATA_SRAM_RESP_CNT_EN
   logic [31:0] r_rd_cnt;
   logic [31:0] r_wr_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_cnt <= 32'h0;
         r_wr_cnt <= 32'h0;
      end else if (w_fire) begin
         if (w_acc_rd && (r_rd_cnt != 32'hffff_ffff)) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
         end
         if (!w_acc_rd && (r_wr_cnt != 32'hffff_ffff)) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
         end
      end
   end

   assign sram.rd_cnt = r_rd_cnt;
   assign sram.wr_cnt = r_wr_cnt;
`endif
endmodule
